// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-mode codes, receiver FSM encoding and
// small helpers used by the receiver and its bit sampler.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    typedef logic [2:0] rx_state_t;

    localparam rx_state_t ST_IDLE   = 3'd0;
    localparam rx_state_t ST_START  = 3'd1;
    localparam rx_state_t ST_DATA   = 3'd2;
    localparam rx_state_t ST_PARITY = 3'd3;
    localparam rx_state_t ST_STOP   = 3'd4;

    function automatic int sb_width(input int oversample);
        return $clog2(oversample);
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_ext_if.sv
// Holding-register handshake between the UART receiver and its consumer.
interface uart_rx_ext_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 read;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        output data, valid, parity_err, frame_err, overrun, busy,
        input  read
    );

    modport slave (
        input  data, valid, parity_err, frame_err, overrun, busy,
        output read
    );
endinterface

// File: rtl/uart_bit_sampler.sv
// Synchronises the serial line, tracks the sub-bit position on baud ticks and
// votes three mid-bit samples into one bit decision.
module uart_bit_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic baud_tick,
    input  logic rx,
    input  logic start,
    input  logic run,
    output logic rx_s,
    output logic bit_val,
    output logic decide,
    output logic bit_end
);

    localparam int SB_W = sb_width(OVERSAMPLE);
    localparam int H    = OVERSAMPLE / 2;

    localparam logic [SB_W-1:0] SB_LAST  = SB_W'(OVERSAMPLE - 1);
    localparam logic [SB_W-1:0] SB_EARLY = SB_W'(H - 1);
    localparam logic [SB_W-1:0] SB_MID   = SB_W'(H);
    localparam logic [SB_W-1:0] SB_DEC   = SB_W'(H + 1);

    logic            rx_meta;
    logic [SB_W-1:0] sb;
    logic            samp_early;
    logic            samp_mid;

    // Synchroniser resets to the idle level so reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // The detecting tick counts as sub-bit 0 of the start bit, hence the load of 1.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sb <= '0;
        end else if (baud_tick) begin
            if (start) begin
                sb <= SB_W'(1);
            end else if (!run) begin
                sb <= '0;
            end else if (sb == SB_LAST) begin
                sb <= '0;
            end else begin
                sb <= sb + SB_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            samp_early <= 1'b1;
            samp_mid   <= 1'b1;
        end else if (baud_tick && run) begin
            if (sb == SB_EARLY) begin
                samp_early <= rx_s;
            end
            if (sb == SB_MID) begin
                samp_mid <= rx_s;
            end
        end
    end

    // The third sample is the live line value on the decision tick itself.
    assign bit_val = majority3(samp_early, samp_mid, rx_s);
    assign decide  = baud_tick && run && (sb == SB_DEC);
    assign bit_end = baud_tick && run && (sb == SB_LAST);

endmodule

// File: rtl/uart_rx_ext.sv
// UART receiver with configurable width, runtime parity / stop-bit selection,
// false-start rejection and a flagged holding register for the consumer.
module uart_rx_ext
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             baud_tick,
    input  logic             rx,
    input  logic [1:0]       parity_mode,
    input  logic             two_stop,
    uart_rx_ext_if.master    bus
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    rx_state_t            state;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic [1:0]           par_cfg;
    logic                 two_cfg;
    logic                 second_stop;
    logic                 perr;
    logic                 ferr;

    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 parity_err_q;
    logic                 frame_err_q;
    logic                 overrun_q;

    logic rx_s;
    logic bit_val;
    logic decide;
    logic bit_end;
    logic start_det;
    logic par_on;
    logic par_expect;
    logic last_stop;
    logic done;

    assign start_det  = (state == ST_IDLE) && baud_tick && !rx_s;
    assign par_on     = (par_cfg == PAR_EVEN) || (par_cfg == PAR_ODD);
    assign par_expect = (^shreg) ^ (par_cfg == PAR_ODD);
    assign last_stop  = !two_cfg || second_stop;
    assign done       = (state == ST_STOP) && decide && last_stop;

    uart_bit_sampler #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_sampler (
        .clk       (clk),
        .reset_n   (reset_n),
        .baud_tick (baud_tick),
        .rx        (rx),
        .start     (start_det),
        .run       (state != ST_IDLE),
        .rx_s      (rx_s),
        .bit_val   (bit_val),
        .decide    (decide),
        .bit_end   (bit_end)
    );

    // Frame FSM; configuration is frozen at start detect so mid-frame changes are harmless.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            bit_idx     <= '0;
            shreg       <= '0;
            par_cfg     <= PAR_NONE;
            two_cfg     <= 1'b0;
            second_stop <= 1'b0;
            perr        <= 1'b0;
            ferr        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_det) begin
                        state       <= ST_START;
                        par_cfg     <= parity_mode;
                        two_cfg     <= two_stop;
                        second_stop <= 1'b0;
                        perr        <= 1'b0;
                        ferr        <= 1'b0;
                        bit_idx     <= '0;
                    end
                end
                ST_START: begin
                    if (decide && bit_val) begin
                        state <= ST_IDLE;
                    end else if (bit_end) begin
                        state   <= ST_DATA;
                        bit_idx <= '0;
                    end
                end
                ST_DATA: begin
                    if (decide) begin
                        shreg <= {bit_val, shreg[DATA_BITS-1:1]};
                    end
                    if (bit_end) begin
                        if (bit_idx == IDX_LAST) begin
                            state <= par_on ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (decide && (bit_val != par_expect)) begin
                        perr <= 1'b1;
                    end
                    if (bit_end) begin
                        state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    // Leaving at the decision tick keeps the back half of the stop bit free for a new start.
                    if (decide) begin
                        if (!bit_val) begin
                            ferr <= 1'b1;
                        end
                        if (last_stop) begin
                            state <= ST_IDLE;
                        end
                    end else if (bit_end) begin
                        second_stop <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Holding register; a completing frame takes priority over a simultaneous read.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q       <= '0;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else if (done) begin
            data_q       <= shreg;
            parity_err_q <= perr;
            frame_err_q  <= ferr | !bit_val;
            overrun_q    <= valid_q && !bus.read;
            valid_q      <= 1'b1;
        end else if (bus.read && valid_q) begin
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end
    end

    assign bus.data       = data_q;
    assign bus.valid      = valid_q;
    assign bus.parity_err = parity_err_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overrun    = overrun_q;
    assign bus.busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_ext.sv
// Directed scoreboard bench for uart_rx_ext: an 8-bit and a 7-bit receiver
// fed from bench-built serial frames, results checked against queued expectations.
module tb_uart_rx_ext;
    import uart_pkg::*;

    typedef struct {
        int         which;
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        logic       ovr;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       baud_tick = 1'b0;
    logic       rx8 = 1'b1;
    logic       rx7 = 1'b1;
    logic [1:0] parity_mode = PAR_NONE;
    logic       two_stop = 1'b0;

    int   tick_count = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];

    uart_rx_ext_if #(.DATA_BITS(8)) bus8 ();
    uart_rx_ext_if #(.DATA_BITS(7)) bus7 ();

    uart_rx_ext #(.DATA_BITS(8), .OVERSAMPLE(16)) dut8 (
        .clk         (clk),
        .reset_n     (reset_n),
        .baud_tick   (baud_tick),
        .rx          (rx8),
        .parity_mode (parity_mode),
        .two_stop    (two_stop),
        .bus         (bus8)
    );

    uart_rx_ext #(.DATA_BITS(7), .OVERSAMPLE(16)) dut7 (
        .clk         (clk),
        .reset_n     (reset_n),
        .baud_tick   (baud_tick),
        .rx          (rx7),
        .parity_mode (parity_mode),
        .two_stop    (two_stop),
        .bus         (bus7)
    );

    always #5 clk = ~clk;

    // One-clock baud tick every third clock, raised on the falling edge.
    initial begin
        forever begin
            repeat (2) @(negedge clk);
            baud_tick = 1'b1;
            tick_count++;
            @(negedge clk);
            baud_tick = 1'b0;
        end
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        int tgt;
        tgt = tick_count + n;
        wait (tick_count >= tgt);
    endtask

    task automatic drive_rx(input int which, input logic v);
        if (which == 7) rx7 = v;
        else rx8 = v;
    endtask

    task automatic set_read(input int which, input logic v);
        if (which == 7) bus7.read = v;
        else bus8.read = v;
    endtask

    function automatic logic valid_of(input int which);
        return (which == 7) ? bus7.valid : bus8.valid;
    endfunction

    function automatic logic xor_bits(input logic [8:0] w, input int n);
        logic x;
        x = 1'b0;
        for (int i = 0; i < n; i++) x ^= w[i];
        return x;
    endfunction

    task automatic do_read(input int which);
        @(negedge clk);
        set_read(which, 1'b1);
        @(negedge clk);
        set_read(which, 1'b0);
    endtask

    task automatic push_exp(input int which, input logic [8:0] d, input logic pe,
                            input logic fe, input logic ov);
        exp_t e;
        e.which = which;
        e.data  = d;
        e.perr  = pe;
        e.ferr  = fe;
        e.ovr   = ov;
        sb_q.push_back(e);
    endtask

    // Serialises one frame; optional mid-bit glitches, read on the completion
    // clock, and an exact completion-time check around the final decision tick.
    task automatic send_frame(input int which, input logic [8:0] word, input int nbits,
                              input logic has_par, input logic par_bit, input int nstop,
                              input logic [1:0] stop_vals, input bit glitch,
                              input bit read_at_done, input bit check_timing);
        logic fb[$];
        int   k0;
        int   done_at;
        int   len;
        fb.push_back(1'b0);
        for (int i = 0; i < nbits; i++) fb.push_back(word[i]);
        if (has_par) fb.push_back(par_bit);
        for (int i = 0; i < nstop; i++) fb.push_back(stop_vals[i]);
        len = fb.size();
        wait_ticks(1);
        k0 = tick_count;
        done_at = k0 + 16 * (len - 1) + 10;
        for (int i = 0; i < len; i++) begin
            drive_rx(which, fb[i]);
            if (glitch) begin
                wait_ticks(8);
                drive_rx(which, !fb[i]);
                wait_ticks(1);
                drive_rx(which, fb[i]);
                wait_ticks(7);
            end else if (i == len - 1 && (read_at_done || check_timing)) begin
                wait (tick_count >= done_at);
                if (check_timing) check("valid_before_done_tick", valid_of(which), 0);
                if (read_at_done) set_read(which, 1'b1);
                @(negedge clk);
                set_read(which, 1'b0);
                if (check_timing) check("valid_after_done_tick", valid_of(which), 1);
                wait (tick_count >= k0 + 16 * len);
            end else begin
                wait_ticks(16);
            end
        end
        drive_rx(which, 1'b1);
        wait_ticks(20);
    endtask

    task automatic expect_frame();
        exp_t       e;
        logic [8:0] d;
        logic       v, pe, fe, ov;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $error("[TB] FAIL scoreboard_pop observed=empty expected=entry");
            return;
        end
        e = sb_q.pop_front();
        if (e.which == 7) begin
            d = {2'b00, bus7.data};
            v = bus7.valid; pe = bus7.parity_err; fe = bus7.frame_err; ov = bus7.overrun;
        end else begin
            d = {1'b0, bus8.data};
            v = bus8.valid; pe = bus8.parity_err; fe = bus8.frame_err; ov = bus8.overrun;
        end
        check($sformatf("dut%0d_valid", e.which), v, 1);
        check($sformatf("dut%0d_data", e.which), d, e.data);
        check($sformatf("dut%0d_parity_err", e.which), pe, e.perr);
        check($sformatf("dut%0d_frame_err", e.which), fe, e.ferr);
        check($sformatf("dut%0d_overrun", e.which), ov, e.ovr);
    endtask

    initial begin
        bus8.read = 1'b0;
        bus7.read = 1'b0;

        // Reset state
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid8", bus8.valid, 0);
        check("rst_data8", bus8.data, 0);
        check("rst_busy8", bus8.busy, 0);
        check("rst_perr8", bus8.parity_err, 0);
        check("rst_ferr8", bus8.frame_err, 0);
        check("rst_ovr8", bus8.overrun, 0);
        check("rst_valid7", bus7.valid, 0);
        check("rst_busy7", bus7.busy, 0);
        reset_n = 1'b1;
        wait_ticks(4);

        // 8N1 0xA5 with exact completion timing
        parity_mode = PAR_NONE;
        two_stop = 1'b0;
        push_exp(8, 9'h0A5, 0, 0, 0);
        send_frame(8, 9'h0A5, 8, 0, 0, 1, 2'b11, 0, 0, 1);
        expect_frame();
        do_read(8);
        check("read_clears_valid", bus8.valid, 0);

        // Even parity, wrong then right parity bit
        parity_mode = PAR_EVEN;
        push_exp(8, 9'h003, xor_bits(9'h003, 8) != 1'b1, 0, 0);
        send_frame(8, 9'h003, 8, 1, 1'b1, 1, 2'b11, 0, 0, 0);
        expect_frame();
        do_read(8);
        push_exp(8, 9'h003, xor_bits(9'h003, 8) != 1'b0, 0, 0);
        send_frame(8, 9'h003, 8, 1, 1'b0, 1, 2'b11, 0, 0, 0);
        expect_frame();
        do_read(8);

        // False start: five ticks low
        parity_mode = PAR_NONE;
        wait_ticks(1);
        rx8 = 1'b0;
        wait_ticks(3);
        check("false_start_busy", bus8.busy, 1);
        wait_ticks(2);
        rx8 = 1'b1;
        wait_ticks(30);
        check("false_start_idle", bus8.busy, 0);
        check("false_start_no_valid", bus8.valid, 0);
        push_exp(8, 9'h03C, 0, 0, 0);
        send_frame(8, 9'h03C, 8, 0, 0, 1, 2'b11, 0, 0, 0);
        expect_frame();
        do_read(8);

        // Two stop bits, second one low
        two_stop = 1'b1;
        push_exp(8, 9'h05A, 0, 1, 0);
        send_frame(8, 9'h05A, 8, 0, 0, 2, 2'b01, 0, 0, 0);
        expect_frame();
        do_read(8);
        two_stop = 1'b0;

        // Overrun, read clearing, read on the completion clock
        push_exp(8, 9'h011, 0, 0, 0);
        send_frame(8, 9'h011, 8, 0, 0, 1, 2'b11, 0, 0, 0);
        expect_frame();
        push_exp(8, 9'h022, 0, 0, 1);
        send_frame(8, 9'h022, 8, 0, 0, 1, 2'b11, 0, 0, 0);
        expect_frame();
        do_read(8);
        check("read_valid", bus8.valid, 0);
        check("read_overrun", bus8.overrun, 0);
        check("read_perr", bus8.parity_err, 0);
        check("read_ferr", bus8.frame_err, 0);
        push_exp(8, 9'h033, 0, 0, 0);
        send_frame(8, 9'h033, 8, 0, 0, 1, 2'b11, 0, 0, 0);
        expect_frame();
        push_exp(8, 9'h044, 0, 0, 0);
        send_frame(8, 9'h044, 8, 0, 0, 1, 2'b11, 0, 1, 0);
        expect_frame();

        // 7-bit odd parity with a one-tick glitch at the middle sample of every bit
        parity_mode = PAR_ODD;
        push_exp(7, 9'h055, 0, 0, 0);
        send_frame(7, 9'h055, 7, 1, xor_bits(9'h055, 7) ^ 1'b1, 1, 2'b11, 1, 0, 0);
        expect_frame();

        // Reset in the middle of a frame
        parity_mode = PAR_NONE;
        wait_ticks(1);
        rx7 = 1'b0;
        wait_ticks(40);
        check("midframe_busy7", bus7.busy, 1);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("midrst_valid7", bus7.valid, 0);
        check("midrst_data7", bus7.data, 0);
        check("midrst_busy7", bus7.busy, 0);
        check("midrst_data8", bus8.data, 0);
        rx7 = 1'b1;
        reset_n = 1'b1;
        wait_ticks(200);
        check("midrst_no_emit7", bus7.valid, 0);
        check("midrst_idle7", bus7.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
